// File: rtl/scaler_pkg.sv
// Shared definitions for the vertical scaler control slice: register map,
// controller state encoding and fixed-point defaults.
package scaler_pkg;

    // Register map of the configuration write port
    localparam logic [1:0] CFG_IN_W  = 2'd0;
    localparam logic [1:0] CFG_IN_H  = 2'd1;
    localparam logic [1:0] CFG_OUT_H = 2'd2;
    localparam logic [1:0] CFG_CMD   = 2'd3;

    // Fraction bits of scale_step (1.0 == 1 << STEP_FRAC_DEF)
    localparam int STEP_FRAC_DEF = 12;

    // Width of scale_step, line_in_size and the dimension registers
    localparam int DIM_W = 16;

    // Sequencing controller states
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_DONE = 2'd2
    } ctrl_state_t;

endpackage

// File: rtl/scaler_div_seq.sv
// Sequential restoring divider: one quotient bit per clock, DW cycles per
// division. done is high during the cycle that computes the last bit, so the
// full quotient is visible from the following cycle onwards.
module scaler_div_seq #(
    parameter int DW = 28,
    parameter int VW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] quotient
);

    localparam int CW = $clog2(DW + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(DW);

    logic [CW-1:0] cnt;
    logic [VW-1:0] rem;
    logic [VW-1:0] dvsr;
    logic [VW:0]   trial;
    logic [VW:0]   trial_sub;
    logic          trial_ge;

    // Shift the next dividend bit into the partial remainder and trial-subtract
    // NOTE: every variable driven here gets a default first, so no latch can be inferred.
    always_comb begin
        trial     = {rem, quotient[DW-1]};
        trial_ge  = (trial >= {1'b0, dvsr});
        trial_sub = trial - {1'b0, dvsr};
    end

    // Iteration state: quotient register doubles as the dividend shift register
    // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy     <= 1'b0;
            cnt      <= '0;
            rem      <= '0;
            dvsr     <= '0;
            quotient <= '0;
        end else if (start && !busy) begin
            busy     <= 1'b1;
            cnt      <= CNT_INIT;
            rem      <= '0;
            dvsr     <= divisor;
            quotient <= dividend;
        end else if (busy) begin
            // Remainder stays below the divisor, so VW bits always suffice
            rem      <= trial_ge ? trial_sub[VW-1:0] : trial[VW-1:0];
            quotient <= {quotient[DW-2:0], trial_ge};
            cnt      <= cnt - 1'b1;
            if (cnt == CW'(1)) begin
                busy <= 1'b0;
            end
        end
    end

    assign done = busy && (cnt == CW'(1));

endmodule

// File: rtl/scaler_v_ctrl.sv
// Configuration and sequencing controller for the vertical cubic line scaler.
// Stages dimensions, computes scale_step = (in_h * LINE_STEP) / out_h, holds
// the result in a shadow until the next input frame start, and checks the
// output line count of every completed output frame.
module scaler_v_ctrl
    import scaler_pkg::*;
#(
    parameter int LINE_STEP       = 4096,
    parameter int STEP_FRAC       = STEP_FRAC_DEF,
    parameter int LINE_TOL        = 2,
    parameter int RESET_STEP      = 4096,
    parameter int RESET_LINE_SIZE = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_we,
    input  logic [1:0]  cfg_addr,
    input  logic [15:0] cfg_wdata,
    output logic        busy,
    output logic        pending,
    output logic        cfg_err,
    output logic [15:0] scale_step,
    output logic [15:0] line_in_size,
    input  logic        de_i,
    input  logic        vs_i,
    input  logic        de_o,
    input  logic        hs_o,
    input  logic        vs_o,
    output logic        frame_done,
    output logic [15:0] out_line_cnt,
    output logic        line_err
);

    localparam int DIVIDEND_W = DIM_W + STEP_FRAC;

    // Staging registers, freely writable at any time
    logic [DIM_W-1:0] in_w;
    logic [DIM_W-1:0] in_h;
    logic [DIM_W-1:0] out_h;

    // Operands captured when a computation starts
    logic [DIM_W-1:0] snap_in_w;
    logic [DIM_W-1:0] snap_out_h;

    // Computed configuration awaiting a frame boundary
    logic [DIM_W-1:0] shadow_step;
    logic [DIM_W-1:0] shadow_size;
    logic [DIM_W-1:0] shadow_out_h;

    // out_h of the configuration currently driving the scaler
    logic [DIM_W-1:0] act_out_h;

    ctrl_state_t state;
    ctrl_state_t next_state;

    logic                  cmd_wr;
    logic                  cmd_accept;
    logic                  cmd_zero;
    logic                  div_start;
    logic                  done_fire;
    logic                  apply;
    logic                  div_busy;
    logic                  div_done;
    logic [DIVIDEND_W-1:0] div_dividend;
    logic [DIVIDEND_W-1:0] div_quot;
    logic                  quot_sat;
    logic [DIM_W-1:0]      quot_clamped;

    logic                  first_frame;
    logic [DIM_W-1:0]      line_cnt;
    logic [DIM_W-1:0]      line_diff;

    assign cmd_wr       = cfg_we && (cfg_addr == CFG_CMD);
    assign div_dividend = DIVIDEND_W'(in_h) * DIVIDEND_W'(LINE_STEP);
    assign quot_sat     = |div_quot[DIVIDEND_W-1:DIM_W];
    assign quot_clamped = quot_sat ? {DIM_W{1'b1}} : div_quot[DIM_W-1:0];
    assign apply        = de_i && vs_i && pending;
    assign busy         = (state != S_IDLE);

    scaler_div_seq #(
        .DW (DIVIDEND_W),
        .VW (DIM_W)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .dividend (div_dividend),
        .divisor  (out_h),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_quot)
    );

    // Capture dimension writes into the staging registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_w  <= '0;
            in_h  <= '0;
            out_h <= '0;
        end else if (cfg_we) begin
            case (cfg_addr)
                CFG_IN_W:  in_w  <= cfg_wdata;
                CFG_IN_H:  in_h  <= cfg_wdata;
                CFG_OUT_H: out_h <= cfg_wdata;
                default:   ;
            endcase
        end
    end

    // Controller state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and control strobes; commands outside IDLE are dropped
    always_comb begin
        next_state = state;
        cmd_accept = 1'b0;
        cmd_zero   = 1'b0;
        div_start  = 1'b0;
        done_fire  = 1'b0;
        case (state)
            S_IDLE: begin
                if (cmd_wr) begin
                    cmd_accept = 1'b1;
                    if (out_h == '0) begin
                        cmd_zero = 1'b1;
                    end else if (!div_busy) begin
                        div_start  = 1'b1;
                        next_state = S_DIV;
                    end
                end
            end
            S_DIV: begin
                if (div_done) begin
                    next_state = S_DONE;
                end
            end
            S_DONE: begin
                done_fire  = 1'b1;
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // Operand snapshot, shadow update, error flag and pending handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap_in_w    <= '0;
            snap_out_h   <= '0;
            shadow_step  <= '0;
            shadow_size  <= '0;
            shadow_out_h <= '0;
            pending      <= 1'b0;
            cfg_err      <= 1'b0;
        end else begin
            if (div_start) begin
                snap_in_w  <= in_w;
                snap_out_h <= out_h;
            end
            if (cmd_accept) begin
                cfg_err <= cmd_zero;
            end
            if (done_fire) begin
                shadow_step  <= quot_clamped;
                // in_w == 0 deliberately wraps to 0xFFFF
                shadow_size  <= snap_in_w - 1'b1;
                shadow_out_h <= snap_out_h;
                pending      <= 1'b1;
                if (quot_sat) begin
                    cfg_err <= 1'b1;
                end
            end else if (apply) begin
                // A result landing on the apply edge stays pending for the next frame
                pending <= 1'b0;
            end
        end
    end

    // Load the active configuration at an input frame start
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scale_step   <= DIM_W'(RESET_STEP);
            line_in_size <= DIM_W'(RESET_LINE_SIZE);
            act_out_h    <= '0;
        end else if (apply) begin
            scale_step   <= shadow_step;
            line_in_size <= shadow_size;
            act_out_h    <= shadow_out_h;
        end
    end

    // Absolute distance between the closing frame's line count and the target
    always_comb begin
        line_diff = (line_cnt >= act_out_h) ? (line_cnt - act_out_h)
                                            : (act_out_h - line_cnt);
    end

    // Output-frame line counter and per-frame check
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            first_frame  <= 1'b1;
            line_cnt     <= '0;
            out_line_cnt <= '0;
            frame_done   <= 1'b0;
            line_err     <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (cmd_accept) begin
                line_err <= 1'b0;
            end
            if (vs_o) begin
                // A valid pixel on the frame-start strobe is already line 1
                line_cnt <= de_o ? DIM_W'(1) : '0;
                if (first_frame) begin
                    first_frame <= 1'b0;
                end else begin
                    out_line_cnt <= line_cnt;
                    frame_done   <= 1'b1;
                    if (line_diff > DIM_W'(LINE_TOL)) begin
                        line_err <= 1'b1;
                    end
                end
            end else if (de_o && hs_o && (line_cnt != {DIM_W{1'b1}})) begin
                line_cnt <= line_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_scaler_v_ctrl.sv
// Directed bench for scaler_v_ctrl: configuration compute, apply timing,
// error cases, command/apply collisions, output line monitor and reset.
module tb_scaler_v_ctrl;
    import scaler_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_addr = 2'd0;
    logic [15:0] cfg_wdata = 16'd0;
    logic        busy;
    logic        pending;
    logic        cfg_err;
    logic [15:0] scale_step;
    logic [15:0] line_in_size;
    logic        de_i = 1'b0;
    logic        vs_i = 1'b0;
    logic        de_o = 1'b0;
    logic        hs_o = 1'b0;
    logic        vs_o = 1'b0;
    logic        frame_done;
    logic [15:0] out_line_cnt;
    logic        line_err;

    int errors = 0;
    int checks = 0;
    int n_busy;

    scaler_v_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_we       (cfg_we),
        .cfg_addr     (cfg_addr),
        .cfg_wdata    (cfg_wdata),
        .busy         (busy),
        .pending      (pending),
        .cfg_err      (cfg_err),
        .scale_step   (scale_step),
        .line_in_size (line_in_size),
        .de_i         (de_i),
        .vs_i         (vs_i),
        .de_o         (de_o),
        .hs_o         (hs_o),
        .vs_o         (vs_o),
        .frame_done   (frame_done),
        .out_line_cnt (out_line_cnt),
        .line_err     (line_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // All stimulus tasks start and end on a falling edge
    task automatic wr(input logic [1:0] a, input logic [15:0] d);
        cfg_we    = 1'b1;
        cfg_addr  = a;
        cfg_wdata = d;
        @(negedge clk);
        cfg_we    = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic in_frame();
        de_i = 1'b1;
        vs_i = 1'b1;
        @(negedge clk);
        de_i = 1'b0;
        vs_i = 1'b0;
    endtask

    task automatic out_line(input logic v);
        de_o = 1'b1;
        hs_o = 1'b1;
        vs_o = v;
        @(negedge clk);
        de_o = 1'b0;
        hs_o = 1'b0;
        vs_o = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_pending", pending, 0);
        check("rst_cfg_err", cfg_err, 0);
        check("rst_step", scale_step, 4096);
        check("rst_size", line_in_size, 1023);
        check("rst_frame_done", frame_done, 0);
        check("rst_line_cnt", out_line_cnt, 0);
        check("rst_line_err", line_err, 0);
        rst = 1'b0;
        @(negedge clk);

        // 1080 -> 720, busy window length and apply at input frame start
        wr(CFG_IN_W, 16'd1920);
        wr(CFG_IN_H, 16'd1080);
        wr(CFG_OUT_H, 16'd720);
        wr(CFG_CMD, 16'd0);
        wait_idle(n_busy);
        check("t1_busy_cycles", n_busy, 29);
        check("t1_pending", pending, 1);
        check("t1_step_not_yet", scale_step, 4096);
        in_frame();
        check("t1_step", scale_step, 6144);
        check("t1_size", line_in_size, 1919);
        check("t1_pending_clr", pending, 0);

        // Output monitor: 720, 720, 700 lines against out_h=720
        out_line(1'b1);
        check("mon_first_no_pulse", frame_done, 0);
        repeat (719) out_line(1'b0);
        out_line(1'b1);
        check("mon_f1_pulse", frame_done, 1);
        check("mon_f1_cnt", out_line_cnt, 720);
        check("mon_f1_err", line_err, 0);
        out_line(1'b0);
        check("mon_pulse_one_cycle", frame_done, 0);
        repeat (718) out_line(1'b0);
        out_line(1'b1);
        check("mon_f2_cnt", out_line_cnt, 720);
        check("mon_f2_err", line_err, 0);
        repeat (699) out_line(1'b0);
        out_line(1'b1);
        check("mon_f3_cnt", out_line_cnt, 700);
        check("mon_f3_err", line_err, 1);

        // 720 -> 1080, truncated quotient; command clears line_err
        wr(CFG_IN_H, 16'd720);
        wr(CFG_OUT_H, 16'd1080);
        wr(CFG_CMD, 16'd0);
        check("t2_line_err_clr", line_err, 0);
        wait_idle(n_busy);
        check("t2_busy_cycles", n_busy, 29);
        check("t2_cfg_err", cfg_err, 0);
        in_frame();
        check("t2_step", scale_step, 2730);

        // out_h = 0 is rejected without starting the divider
        wr(CFG_OUT_H, 16'd0);
        wr(CFG_CMD, 16'd0);
        check("t3_cfg_err", cfg_err, 1);
        check("t3_busy", busy, 0);
        check("t3_pending", pending, 0);
        check("t3_step_kept", scale_step, 2730);

        // Saturating quotient
        wr(CFG_IN_H, 16'd65535);
        wr(CFG_OUT_H, 16'd1);
        wr(CFG_CMD, 16'd0);
        check("t4_cfg_err_clr", cfg_err, 0);
        check("t4_busy", busy, 1);
        wait_idle(n_busy);
        check("t4_busy_cycles", n_busy, 29);
        check("t4_cfg_err", cfg_err, 1);
        check("t4_pending", pending, 1);
        in_frame();
        check("t4_step", scale_step, 16'hFFFF);
        check("t4_size", line_in_size, 1919);

        // Result A pending, then recompute B; a command while busy is dropped
        wr(CFG_IN_W, 16'd1280);
        wr(CFG_IN_H, 16'd1080);
        wr(CFG_OUT_H, 16'd720);
        wr(CFG_CMD, 16'd0);
        wait_idle(n_busy);
        check("t5_a_pending", pending, 1);
        wr(CFG_IN_W, 16'd640);
        wr(CFG_IN_H, 16'd720);
        wr(CFG_OUT_H, 16'd1080);
        wr(CFG_CMD, 16'd0);           // edge 1 of B
        wr(CFG_IN_H, 16'd1080);       // edge 2
        wr(CFG_OUT_H, 16'd540);       // edge 3
        wr(CFG_CMD, 16'd0);           // edge 4, ignored
        repeat (25) @(negedge clk);   // edges 5..29
        check("t5_busy_last", busy, 1);
        in_frame();                   // edge 30: DONE and apply together
        check("t5_busy_end", busy, 0);
        check("t5_step_old", scale_step, 6144);
        check("t5_size_old", line_in_size, 1279);
        check("t5_pending_kept", pending, 1);
        in_frame();
        check("t5_step_new", scale_step, 2730);
        check("t5_size_new", line_in_size, 639);
        check("t5_pending_clr", pending, 0);

        // Build non-reset state, then reset mid-frame
        wr(CFG_IN_H, 16'd1080);
        wr(CFG_OUT_H, 16'd720);
        wr(CFG_CMD, 16'd0);
        wait_idle(n_busy);
        wr(CFG_OUT_H, 16'd0);
        wr(CFG_CMD, 16'd0);
        check("t6_zero_cfg_err", cfg_err, 1);
        check("t6_zero_pending_kept", pending, 1);
        out_line(1'b1);               // closes a 1-line frame against out_h=1080
        check("t6_short_cnt", out_line_cnt, 1);
        check("t6_short_err", line_err, 1);
        out_line(1'b0);
        out_line(1'b0);
        de_o = 1'b1;
        hs_o = 1'b1;
        #2 rst = 1'b1;
        #1;
        check("rr_busy", busy, 0);
        check("rr_pending", pending, 0);
        check("rr_cfg_err", cfg_err, 0);
        check("rr_step", scale_step, 4096);
        check("rr_size", line_in_size, 1023);
        check("rr_frame_done", frame_done, 0);
        check("rr_line_cnt", out_line_cnt, 0);
        check("rr_line_err", line_err, 0);
        de_o = 1'b0;
        hs_o = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        out_line(1'b1);
        check("rr_first_no_pulse", frame_done, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/scaler_v_ctrl.md
Name: scaler_v_ctrl

Overview:
Configuration and sequencing controller for the vertical cubic line scaler (scaler_v).
- Accepts input width, input height and output height over a simple register-write port.
- Computes the fixed-point vertical scale_step with an iterative divider.
- Applies scale_step and line_in_size to the scaler only at an input frame boundary.
- Monitors the scaler output stream and reports per-frame output line count and mismatch errors.

Parameters:
LINE_STEP, 4096, fixed-point 1.0 used by the scaler; must be a power of two.
STEP_FRAC, 12, log2(LINE_STEP).
LINE_TOL, 2, allowed |output lines - out_h| before line_err is raised.
RESET_STEP, 4096, scale_step value after reset (1:1).
RESET_LINE_SIZE, 1023, line_in_size value after reset.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
cfg_we  in  1  register write strobe
cfg_addr  in  2  0=in_w, 1=in_h, 2=out_h, 3=command (any write starts compute)
cfg_wdata  in  16  write data
busy  out  1  divider running
pending  out  1  computed config waiting for frame boundary
cfg_err  out  1  sticky: out_h==0 or quotient saturated
scale_step  out  16  to scaler, unsigned fixed point with STEP_FRAC fraction bits
line_in_size  out  16  to scaler, in_w-1
de_i  in  1  scaler input stream strobe (same net as scaler de_i)
vs_i  in  1  scaler input frame start
de_o, hs_o, vs_o  in  1 each  scaler output strobes
frame_done  out  1  one-cycle pulse on each output vs_o (after the first)
out_line_cnt  out  16  output lines counted in the previous output frame
line_err  out  1  sticky line-count mismatch

Behaviour:
- Reset values (async, on rst):
  - busy=0, pending=0, cfg_err=0.
  - scale_step=RESET_STEP, line_in_size=RESET_LINE_SIZE.
  - frame_done=0, out_line_cnt=0, line_err=0.
  - All staging registers are 0.
  - Monitor is in the "first frame" state.
- Staging registers in_w, in_h, out_h are written on cfg_we with addr 0-2 at any time, including while busy. The divider uses a snapshot taken at command time.
- FSM states: IDLE, DIV, DONE.
  - IDLE, on cfg_we && addr==3:
    - Snapshot operands.
    - Clear cfg_err and line_err.
    - If out_h==0: set cfg_err, stay IDLE, pending unchanged.
    - Otherwise: go to DIV and set busy=1.
  - DIV: restoring division of N = in_h << STEP_FRAC (28 bits) by out_h, one quotient bit per cycle, 28 cycles.
  - DONE, one cycle:
    - If the quotient exceeds 0xFFFF, clamp result to 0xFFFF and set cfg_err.
    - Store result and in_w-1 into shadow registers.
    - Set pending=1, busy=0, return to IDLE.
  - Latency: busy is high for exactly 29 cycles after the command edge. pending rises on the 30th edge.
  - Quotient truncates toward zero.
  - Command writes while busy are ignored, and the staging snapshot is not altered.
  - A new command while pending=1 recomputes; the newer shadow overwrites the older one.
- Apply:
  - On the first edge with de_i && vs_i && pending, load scale_step and line_in_size from shadow and clear pending.
  - Outputs change on that edge, the same edge on which the scaler re-arms its output counter.
  - If DONE and apply occur on the same edge, apply uses the old shadow and pending stays 1.
  - in_w==0 gives line_in_size=0xFFFF; this is passed through without error.
- Monitor:
  - Line counter increments on de_o && hs_o and saturates at 0xFFFF.
  - On de_o && vs_o, the current pixel also counts as line 1 of the new frame.
  - On vs_o after the first frame: latch out_line_cnt, pulse frame_done next cycle, and compare against the out_h of the active (applied) config.
  - Set line_err if the difference is greater than LINE_TOL.
  - The first vs_o after reset only restarts the counter: no pulse, no check.
  - The active out_h used for the check updates at apply time together with scale_step.

Decomposition:
- Package scaler_pkg holds:
  - register address constants CFG_IN_W, CFG_IN_H, CFG_OUT_H, CFG_CMD;
  - FSM state encoding;
  - STEP_FRAC default.
- One sub-module: scaler_div_seq, a sequential restoring divider with ports start, dividend[27:0], divisor[15:0], busy, done, quotient[27:0].

Test Plan:
- in_h=1080, out_h=720, in_w=1920, command -> busy high 29 cycles, pending=1. At next de_i&vs_i: scale_step=6144, line_in_size=1919, pending=0.
- in_h=720, out_h=1080 -> scale_step=2730 (truncated), cfg_err=0.
- out_h=0, command -> cfg_err=1 next cycle, busy stays 0, scale_step unchanged.
- in_h=65535, out_h=1 -> scale_step=0xFFFF, cfg_err=1.
- Command while busy, and DONE coinciding with de_i&vs_i -> second command ignored. Old shadow is applied, pending stays 1 and applies at the following frame.
- Drive 3 output frames of 720, 720, 700 lines with out_h=720 -> no frame_done on first vs_o. Then out_line_cnt=720 with line_err=0, then 700 with line_err=1. Assert rst mid-frame -> all outputs return to reset values immediately.
